// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: takes one read/write command and issues SINGLE/INCR beats of a
// deterministic SEED+k pattern, self-checking read data and honouring wait states and ERROR.
module ahb_burst_master #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          MAX_LEN = 16,
  parameter int          LEN_W   = 5,
  parameter logic [31:0] SEED    = 32'hA5A5_0000
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              start,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready_in,
  input  logic [1:0]        hresp,
  output logic [2:0]        dbg_state
);

  localparam int         STEP      = DATA_W / 8;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;
  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    abeat_q, abeat_d;
  logic [LEN_W-1:0]    dbeat_q, dbeat_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic [1:0]          htrans_q, htrans_d;
  logic [2:0]          hburst_q, hburst_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [LEN_W-1:0]    mism_q, mism_d;

  logic [LEN_W-1:0]    len_eff;
  logic [ADDR_W-1:0]   addr_next;
  logic                cross_1k;
  logic                data_phase;
  logic                err_resp;
  logic                rd_bad;

  function automatic logic [DATA_W-1:0] pattern(input logic [LEN_W-1:0] k);
    logic [31:0] v;
    v = SEED + 32'(k);
    return DATA_W'(v);
  endfunction

  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (cmd_len > LEN_W'(MAX_LEN)) begin
      len_eff = LEN_W'(MAX_LEN);
    end
  end

  // Handshake: an address phase (htrans != IDLE) is accepted on a rising edge with
  // hready_in=1; its data phase completes on the next edge that also sees hready_in=1.
  assign addr_next  = haddr_q + ADDR_W'(STEP);
  assign cross_1k   = (addr_next[9:0] == 10'd0);
  assign data_phase = (state_q == S_BURST) || (state_q == S_LAST);
  assign err_resp   = data_phase && (hresp == RESP_ERR);
  assign rd_bad     = data_phase && !write_q && hready_in && (hresp == RESP_OKAY) &&
                      (hrdata != pattern(dbeat_q));

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    len_d    = len_q;
    abeat_d  = abeat_q;
    dbeat_d  = dbeat_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hburst_d = hburst_q;
    hwdata_d = hwdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    mism_d   = mism_q;

    if (rd_bad && (mism_q != '1)) begin
      mism_d = mism_q + LEN_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          state_d  = S_ADDR;
          write_d  = cmd_write;
          len_d    = len_eff;
          abeat_d  = '0;
          dbeat_d  = '0;
          haddr_d  = cmd_addr;
          htrans_d = TR_NONSEQ;
          hburst_d = (len_eff == LEN_W'(1)) ? HB_SINGLE : HB_INCR;
          busy_d   = 1'b1;
          error_d  = 1'b0;
          mism_d   = '0;
        end
      end
      S_ADDR, S_BURST: begin
        if (err_resp) begin
          // First ERROR cycle cancels the pending address; the second one ends the command.
          htrans_d = TR_IDLE;
          if (hready_in) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LAST;
          end
        end else if (hready_in) begin
          dbeat_d = abeat_q;
          if (write_q) begin
            hwdata_d = pattern(abeat_q);
          end
          if (abeat_q == len_q - LEN_W'(1)) begin
            state_d  = S_LAST;
            htrans_d = TR_IDLE;
          end else begin
            state_d  = S_BURST;
            haddr_d  = addr_next;
            htrans_d = cross_1k ? TR_NONSEQ : TR_SEQ;
            abeat_d  = abeat_q + LEN_W'(1);
          end
        end
      end
      S_LAST: begin
        if (hready_in) begin
          if (err_resp) begin
            error_d = 1'b1;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      len_q    <= '0;
      abeat_q  <= '0;
      dbeat_q  <= '0;
      haddr_q  <= '0;
      htrans_q <= TR_IDLE;
      hburst_q <= HB_SINGLE;
      hwdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      mism_q   <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      len_q    <= len_d;
      abeat_q  <= abeat_d;
      dbeat_q  <= dbeat_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      hwdata_q <= hwdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      mism_q   <= mism_d;
    end
  end

  // done/busy are registered off the DONE state, so they lag it by one cycle.
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign mismatch_cnt = mism_q;
  assign haddr        = haddr_q;
  assign htrans       = err_resp ? TR_IDLE : htrans_q;
  assign hwrite       = write_q;
  assign hsize        = 3'($clog2(DATA_W / 8));
  assign hburst       = hburst_q;
  assign hwdata       = hwdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: a scripted AHB slave, a bus monitor and expected queues.
module tb_ahb_burst_master;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          LEN_W  = 5;
  localparam logic [31:0] SEED   = 32'hA5A5_0000;

  logic              hclk;
  logic              hreset;
  logic              start;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy;
  logic              done;
  logic              error;
  logic [LEN_W-1:0]  mismatch_cnt;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready_in;
  logic [1:0]        hresp;
  logic [2:0]        dbg_state;

  ahb_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LEN(16), .LEN_W(LEN_W), .SEED(SEED)
  ) dut (
    .hclk(hclk), .hreset(hreset), .start(start), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .busy(busy), .done(done), .error(error),
    .mismatch_cnt(mismatch_cnt), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata),
    .hready_in(hready_in), .hresp(hresp), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  int cyc_cnt = 0;
  always @(posedge hclk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_trans_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] act_addr_q[$];
  logic [31:0] act_trans_q[$];
  logic [31:0] act_burst_q[$];
  logic [31:0] act_wdata_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [2:0] exp_burst);
    check_eq({tag, "_naddr"}, 64'(act_addr_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size(); i++) begin
      if (i < act_addr_q.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), act_addr_q[i], exp_addr_q[i]);
        check_eq($sformatf("%s_trans%0d", tag, i), act_trans_q[i], exp_trans_q[i]);
        check_eq($sformatf("%s_burst%0d", tag, i), act_burst_q[i], 32'(exp_burst));
      end
    end
    check_eq({tag, "_nwdata"}, 64'(act_wdata_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_wdata_q.size()) begin
        check_eq($sformatf("%s_wdata%0d", tag, i), act_wdata_q[i], exp_q[i]);
      end
    end
  endtask

  // Expected beats for a burst that stays inside one 1KB page.
  task automatic exp_beats(input logic [31:0] addr, input int n, input bit wr);
    exp_addr_q.delete();
    exp_trans_q.delete();
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_addr_q.push_back(addr + 32'(4 * k));
      exp_trans_q.push_back((k == 0) ? 32'h2 : 32'h3);
      if (wr) exp_q.push_back(SEED + 32'(k));
    end
  endtask

  // ---------------- scripted slave ----------------
  logic [31:0] base_addr = '0;
  int          wait_beat = -1;
  int          wait_left = 0;
  int          err_beat  = -1;
  int          bad_beat  = -1;

  bit          dph_valid = 1'b0;
  logic [31:0] dph_addr  = '0;
  bit          dph_write = 1'b0;
  int          err_stage = 0;

  bit          rec_valid  = 1'b0;
  logic        rec_hready = 1'b1;
  logic [1:0]  rec_htrans = '0;
  logic [31:0] rec_haddr  = '0;
  logic        rec_hwrite = 1'b0;
  logic [1:0]  rec_hresp  = '0;
  logic        rec_hreset = 1'b1;
  logic [2:0]  rec_hburst = '0;
  logic [31:0] rec_hwdata = '0;

  initial begin
    int b;
    hready_in = 1'b1;
    hresp     = 2'b00;
    hrdata    = '0;
    forever begin
      @(posedge hclk);
      #1;
      if (rec_hreset) begin
        dph_valid = 1'b0;
        err_stage = 0;
      end else if (rec_hready) begin
        dph_valid = rec_htrans[1];
        dph_addr  = rec_haddr;
        dph_write = rec_hwrite;
      end
      hready_in = 1'b1;
      hresp     = 2'b00;
      hrdata    = '0;
      if (dph_valid) begin
        b = int'((dph_addr - base_addr) >> 2);
        hrdata = SEED + 32'(b);
        if (b == bad_beat) hrdata = hrdata ^ 32'h0000_0100;
        if (b == err_beat) begin
          hresp = 2'b01;
          if (err_stage == 0) begin
            hready_in = 1'b0;
            err_stage = 1;
          end else begin
            err_stage = 0;
            err_beat  = -1;
          end
        end else if (b == wait_beat && wait_left > 0) begin
          hready_in = 1'b0;
          wait_left--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int done_cnt = 0;
  int done_cyc = 0;

  initial begin
    forever begin
      @(negedge hclk);
      if (!hreset) begin
        if (hready_in && htrans[1]) begin
          act_addr_q.push_back(haddr);
          act_trans_q.push_back(32'(htrans));
          act_burst_q.push_back(32'(hburst));
        end
        if (dph_valid && dph_write && hready_in && hresp == 2'b00) act_wdata_q.push_back(hwdata);
        if (hresp == 2'b01 && !hready_in) check_eq("err_cancel_htrans", 64'(htrans), 64'h0);
        if (rec_valid && !rec_hready && rec_hresp == 2'b00 && !rec_hreset) begin
          check_eq("wait_haddr", haddr, rec_haddr);
          check_eq("wait_htrans", 64'(htrans), 64'(rec_htrans));
          check_eq("wait_hwrite", 64'(hwrite), 64'(rec_hwrite));
          check_eq("wait_hburst", 64'(hburst), 64'(rec_hburst));
          check_eq("wait_hwdata", hwdata, rec_hwdata);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc_cnt;
        end
      end
      rec_valid  = 1'b1;
      rec_hready = hready_in;
      rec_htrans = htrans;
      rec_haddr  = haddr;
      rec_hwrite = hwrite;
      rec_hresp  = hresp;
      rec_hreset = hreset;
      rec_hburst = hburst;
      rec_hwdata = hwdata;
    end
  end

  // ---------------- driver ----------------
  task automatic clear_act();
    act_addr_q.delete();
    act_trans_q.delete();
    act_burst_q.delete();
    act_wdata_q.delete();
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [LEN_W-1:0] len,
                         input bit restrike, output int lat);
    int c0;
    int d0;
    int i;
    clear_act();
    base_addr = addr;
    @(posedge hclk);
    #1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    start     = 1'b1;
    c0        = cyc_cnt;
    d0        = done_cnt;
    @(posedge hclk);
    #1;
    start = 1'b0;
    if (restrike) begin
      cmd_addr = 32'hDEAD_0000;
      @(posedge hclk);
      #1;
      start = 1'b1;
      @(posedge hclk);
      #1;
      start = 1'b0;
    end
    i = 0;
    while (done_cnt == d0 && i < 80) begin
      @(posedge hclk);
      i++;
    end
    #1;
    check_eq("done_seen", 64'(done_cnt - d0), 64'd1);
    lat = done_cyc - c0;
    repeat (2) @(posedge hclk);
    #1;
  endtask

  // ---------------- tests ----------------
  initial begin
    int lat;
    int i;
    bit found;
    int d0;
    hreset    = 1'b1;
    start     = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    repeat (3) @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    check_eq("rst_htrans", 64'(htrans), 64'h0);
    check_eq("rst_haddr", haddr, 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_done", 64'(done), 64'h0);
    check_eq("rst_error", 64'(error), 64'h0);
    check_eq("rst_mismatch", 64'(mismatch_cnt), 64'h0);
    check_eq("rst_hsize", 64'(hsize), 64'h2);
    check_eq("rst_hburst", 64'(hburst), 64'h0);
    check_eq("rst_hwrite", 64'(hwrite), 64'h0);

    // 1: single write
    run_cmd(1'b1, 32'h8000_0000, 5'd1, 1'b0, lat);
    exp_addr_q = '{32'h8000_0000};
    exp_trans_q = '{32'h2};
    exp_q = '{32'hA5A5_0000};
    check_bus("t1", 3'b000);
    check_eq("t1_latency", 64'(lat), 64'd4);
    check_eq("t1_error", 64'(error), 64'h0);
    check_eq("t1_busy_after", 64'(busy), 64'h0);

    // 2: INCR4 read, pattern returned
    run_cmd(1'b0, 32'h8000_0100, 5'd4, 1'b0, lat);
    exp_beats(32'h8000_0100, 4, 1'b0);
    check_bus("t2", 3'b001);
    check_eq("t2_latency", 64'(lat), 64'd7);
    check_eq("t2_mismatch", 64'(mismatch_cnt), 64'd0);

    // 2b: INCR4 read with beat 2 corrupted
    bad_beat = 2;
    run_cmd(1'b0, 32'h8000_0140, 5'd4, 1'b0, lat);
    bad_beat = -1;
    check_eq("t2b_mismatch", 64'(mismatch_cnt), 64'd1);
    check_eq("t2b_latency", 64'(lat), 64'd7);

    // 3: INCR4 write, two wait states on beat 1
    wait_beat = 1;
    wait_left = 2;
    run_cmd(1'b1, 32'h8000_0200, 5'd4, 1'b0, lat);
    wait_beat = -1;
    exp_beats(32'h8000_0200, 4, 1'b1);
    check_bus("t3", 3'b001);
    check_eq("t3_latency", 64'(lat), 64'd9);
    check_eq("t3_mismatch_cleared", 64'(mismatch_cnt), 64'd0);

    // 4: INCR8 write across the 1KB boundary
    run_cmd(1'b1, 32'h8000_03F0, 5'd8, 1'b0, lat);
    exp_addr_q = '{32'h8000_03F0, 32'h8000_03F4, 32'h8000_03F8, 32'h8000_03FC,
                   32'h8000_0400, 32'h8000_0404, 32'h8000_0408, 32'h8000_040C};
    exp_trans_q = '{32'h2, 32'h3, 32'h3, 32'h3, 32'h2, 32'h3, 32'h3, 32'h3};
    exp_q = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003,
              32'hA5A5_0004, 32'hA5A5_0005, 32'hA5A5_0006, 32'hA5A5_0007};
    check_bus("t4", 3'b001);
    check_eq("t4_latency", 64'(lat), 64'd11);

    // 5: ERROR on beat 2 of INCR8 read
    err_beat = 2;
    run_cmd(1'b0, 32'h8000_1000, 5'd8, 1'b0, lat);
    err_beat = -1;
    exp_beats(32'h8000_1000, 3, 1'b0);
    check_bus("t5", 3'b001);
    check_eq("t5_error", 64'(error), 64'h1);
    check_eq("t5_latency", 64'(lat), 64'd7);
    check_eq("t5_mismatch", 64'(mismatch_cnt), 64'd0);

    // 5b: start re-strobed while busy is ignored; error cleared by the accepted start
    run_cmd(1'b1, 32'h8000_0800, 5'd2, 1'b1, lat);
    exp_beats(32'h8000_0800, 2, 1'b1);
    check_bus("t5b", 3'b001);
    check_eq("t5b_error_cleared", 64'(error), 64'h0);
    check_eq("t5b_latency", 64'(lat), 64'd5);

    // len 0 treated as 1, len 31 clamped to 16
    run_cmd(1'b0, 32'h8000_0900, 5'd0, 1'b0, lat);
    exp_beats(32'h8000_0900, 1, 1'b0);
    check_bus("len0", 3'b000);
    check_eq("len0_latency", 64'(lat), 64'd4);
    run_cmd(1'b0, 32'h8000_0A00, 5'd31, 1'b0, lat);
    exp_beats(32'h8000_0A00, 16, 1'b0);
    check_bus("len31", 3'b001);
    check_eq("len31_latency", 64'(lat), 64'd19);
    check_eq("len31_mismatch", 64'(mismatch_cnt), 64'd0);

    // 6: reset mid-burst at beat 3
    clear_act();
    base_addr = 32'h8000_2000;
    @(posedge hclk);
    #1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h8000_2000;
    cmd_len   = 5'd8;
    start     = 1'b1;
    @(posedge hclk);
    #1;
    start = 1'b0;
    found = 1'b0;
    i = 0;
    while (!found && i < 40) begin
      @(negedge hclk);
      if (htrans != 2'b00 && haddr == 32'h8000_200C) found = 1'b1;
      i++;
    end
    check_eq("t6_reach_beat3", 64'(found), 64'h1);
    @(posedge hclk);
    #1;
    hreset = 1'b1;
    d0 = done_cnt;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    check_eq("t6_htrans_idle", 64'(htrans), 64'h0);
    check_eq("t6_busy_low", 64'(busy), 64'h0);
    repeat (5) @(negedge hclk);
    check_eq("t6_no_done", 64'(done_cnt - d0), 64'd0);
    run_cmd(1'b1, 32'h8000_3000, 5'd2, 1'b0, lat);
    exp_beats(32'h8000_3000, 2, 1'b1);
    check_bus("t6b", 3'b001);
    check_eq("t6b_latency", 64'(lat), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
